arbitro_compuerta: RTL and testbench
====================================

Name: arbitro_compuerta

Overview:
Arbiter and sequencer for the shared barrier gate and PIN checker of a two-lane parking access point. There is one entry lane and one exit lane. The block grants the single PIN checker to one lane at a time and opens the shared gate after a valid PIN. It tracks lot occupancy, blocks entry when the lot is full, and latches a lockout after repeated bad PINs. It sits between the lane sensors and the access datapath (PIN compare, gate driver, alarms).

Parameters:
CAPACIDAD, 8, number of parking spaces; entry requests are refused while ocupacion equals this value
ANCHO_OCUP, 4, width of the occupancy counter; must hold CAPACIDAD
MAX_INTENTOS, 3, consecutive invalid PINs that trigger lockout
TIMEOUT, 1000, clock cycles allowed in VERIFICANDO before abandoning the request
ANCHO_TMR, 10, width of the timeout counter; must hold TIMEOUT-1

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
llegada_entrada  input  1  vehicle present at entry lane, level
llegada_salida  input  1  vehicle present at exit lane, level
pin_valido  input  1  one-cycle pulse from the PIN checker: PIN correct
pin_invalido  input  1  one-cycle pulse from the PIN checker: PIN wrong
sensor_paso  input  1  vehicle has crossed the gate, level
desbloqueo  input  1  supervisor clear of lockout, pulse
habilitar_pin  output  1  PIN checker granted to the selected lane
carril  output  1  selected lane, 0=entry, 1=exit
senal_compuerta  output  1  gate open command
senal_alarma_pin  output  1  one-cycle pulse per invalid PIN
senal_alarma_bloqueo  output  1  lockout active
senal_lleno  output  1  ocupacion == CAPACIDAD
ocupacion  output  ANCHO_OCUP  vehicles currently inside

Behaviour:
- Clocking and reset: single clock domain; reset is asynchronous, active-low. All outputs are registered (Moore).
- Reset values: state=IDLE; every output is 0 except senal_lleno, which is 0 unless CAPACIDAD==0; ocupacion=0; intentos=0; timer=0; ultimo_carril=1, so entry wins the first contention.
- States: IDLE, VERIFICANDO, ABIERTA, BLOQUEO.
- Valid requests:
  - req_e = llegada_entrada & ~senal_lleno
  - req_s = llegada_salida & (ocupacion != 0)
- IDLE:
  - If exactly one request is valid, grant that lane.
  - If both are valid, grant the lane != ultimo_carril.
  - On grant: next edge goes to VERIFICANDO, carril and ultimo_carril take the granted lane, and timer clears.
  - habilitar_pin is 1 from the first VERIFICANDO cycle. Latency from request to grant is 1 cycle.
- VERIFICANDO (habilitar_pin=1), priority order:
  1. Granted lane's arrival sensor deasserts -> IDLE next cycle; intentos unchanged.
  2. pin_invalido=1 (wins if pin_valido is also 1) -> intentos+1 and senal_alarma_pin pulses 1 cycle. If the new intentos == MAX_INTENTOS -> BLOQUEO; otherwise stay in VERIFICANDO with timer cleared.
  3. pin_valido=1 -> ABIERTA; intentos=0.
  4. timer == TIMEOUT-1 -> IDLE; intentos unchanged. Otherwise timer+1.
- ABIERTA (senal_compuerta=1, habilitar_pin=0):
  - Wait for sensor_paso=1. On that edge go to IDLE.
  - Update ocupacion on the same edge: +1 if carril=0, -1 if carril=1.
  - The counter saturates at CAPACIDAD and at 0, so it never wraps.
  - There is no timeout in ABIERTA; the gate stays open until passage.
- BLOQUEO (senal_alarma_bloqueo=1, gate closed, habilitar_pin=0):
  - All lane requests and PIN pulses are ignored.
  - desbloqueo=1 -> IDLE with intentos=0.
- senal_lleno is combinationally equal to (ocupacion == CAPACIDAD) but is driven from the registered ocupacion, so it is glitch-free.
- Reset mid-operation: any state returns to IDLE immediately, the gate closes, and ocupacion clears.
- pin_valido and pin_invalido are ignored outside VERIFICANDO.
- desbloqueo is ignored outside BLOQUEO.

Test Plan:
1. Reset released, llegada_entrada=1, pin_valido pulse, then sensor_paso=1 -> grant 1 cycle after request with carril=0; senal_compuerta=1 the cycle after pin_valido; ocupacion 0->1; back to IDLE.
2. Simultaneous llegada_entrada=1 and llegada_salida=1 with ocupacion=2, repeated for three transactions -> grants alternate 0,1,0; ocupacion goes 3,2,3.
3. Three pin_invalido pulses on entry lane (MAX_INTENTOS=3) -> senal_alarma_pin pulses three times, senal_alarma_bloqueo=1, lane requests ignored; desbloqueo pulse -> IDLE, intentos=0.
4. Fill to CAPACIDAD=8 -> senal_lleno=1, llegada_entrada gets no grant, llegada_salida still granted; after the exit completes, senal_lleno=0.
5. Granted entry with no PIN result for TIMEOUT cycles -> IDLE exactly at cycle TIMEOUT; gate never opens. Separately, drop llegada_entrada mid-verification -> IDLE next cycle.
6. Assert reset low while in ABIERTA -> senal_compuerta=0 and ocupacion=0 asynchronously; pin_valido and pin_invalido together in VERIFICANDO -> counted as invalid.

Source files
------------

// File: rtl/arbitro_compuerta.sv
// arbitro_compuerta: arbiter and sequencer for the shared barrier gate and PIN
// checker of a two-lane (entry/exit) parking access point. It grants the PIN
// checker to one lane at a time, opens the gate after a valid PIN, tracks lot
// occupancy, and latches a lockout after repeated bad PINs.
module arbitro_compuerta #(
   parameter int CAPACIDAD    = 8,
   parameter int ANCHO_OCUP   = 4,
   parameter int MAX_INTENTOS = 3,
   parameter int TIMEOUT      = 1000,
   parameter int ANCHO_TMR    = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  llegada_entrada,
   input  logic                  llegada_salida,
   input  logic                  pin_valido,
   input  logic                  pin_invalido,
   input  logic                  sensor_paso,
   input  logic                  desbloqueo,
   output logic                  habilitar_pin,
   output logic                  carril,
   output logic                  senal_compuerta,
   output logic                  senal_alarma_pin,
   output logic                  senal_alarma_bloqueo,
   output logic                  senal_lleno,
   output logic [ANCHO_OCUP-1:0] ocupacion
);

   localparam int ANCHO_INT = (MAX_INTENTOS < 1) ? 1 : $clog2(MAX_INTENTOS + 1);

   localparam logic [ANCHO_OCUP-1:0] CAP_L   = ANCHO_OCUP'(CAPACIDAD);
   localparam logic [ANCHO_INT-1:0]  MAX_L   = ANCHO_INT'(MAX_INTENTOS);
   localparam logic [ANCHO_TMR-1:0]  TMR_FIN = ANCHO_TMR'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      VERIFICANDO = 2'd1,
      ABIERTA     = 2'd2,
      BLOQUEO     = 2'd3
   } estado_t;

   estado_t               estado, estado_sig;
   logic                  ultimo_carril, ultimo_sig;
   logic                  carril_sig;
   logic [ANCHO_INT-1:0]  intentos, intentos_sig, intentos_inc;
   logic [ANCHO_TMR-1:0]  timer, timer_sig;
   logic [ANCHO_OCUP-1:0] ocup_sig;
   logic                  alarma_pin_sig;
   logic                  req_e, req_s;
   logic                  llegada_activa;

   // A lane only counts as requesting if the move it implies is possible:
   // no entry into a full lot, no exit from an empty one.
   assign req_e          = llegada_entrada & ~senal_lleno;
   assign req_s          = llegada_salida & (ocupacion != '0);
   assign llegada_activa = carril ? llegada_salida : llegada_entrada;
   assign intentos_inc   = intentos + 1'b1;

   // Full flag decoded from the registered count, so it never glitches.
   assign senal_lleno = (ocupacion == CAP_L);

   // Next-state and next-datapath logic for the gate sequencer.
   always_comb begin
      estado_sig     = estado;
      carril_sig     = carril;
      ultimo_sig     = ultimo_carril;
      intentos_sig   = intentos;
      timer_sig      = timer;
      ocup_sig       = ocupacion;
      alarma_pin_sig = 1'b0;
      case (estado)
         IDLE: begin
            if (req_e || req_s) begin
               // On contention the lane that was not served last wins.
               carril_sig = (req_e && req_s) ? ~ultimo_carril : req_s;
               ultimo_sig = carril_sig;
               timer_sig  = '0;
               estado_sig = VERIFICANDO;
            end
         end
         VERIFICANDO: begin
            if (!llegada_activa) begin
               estado_sig = IDLE;
            end else if (pin_invalido) begin
               // A simultaneous valid pulse is treated as a bad PIN.
               intentos_sig   = intentos_inc;
               alarma_pin_sig = 1'b1;
               timer_sig      = '0;
               if (intentos_inc == MAX_L) begin
                  estado_sig = BLOQUEO;
               end
            end else if (pin_valido) begin
               intentos_sig = '0;
               estado_sig   = ABIERTA;
            end else if (timer == TMR_FIN) begin
               estado_sig = IDLE;
            end else begin
               timer_sig = timer + 1'b1;
            end
         end
         ABIERTA: begin
            if (sensor_paso) begin
               estado_sig = IDLE;
               // Saturating update: the count never wraps past full or empty.
               if (!carril && (ocupacion != CAP_L)) begin
                  ocup_sig = ocupacion + 1'b1;
               end else if (carril && (ocupacion != '0)) begin
                  ocup_sig = ocupacion - 1'b1;
               end
            end
         end
         BLOQUEO: begin
            if (desbloqueo) begin
               intentos_sig = '0;
               estado_sig   = IDLE;
            end
         end
         default: begin
            estado_sig = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado <= IDLE;
      end else begin
         estado <= estado_sig;
      end
   end

   // Lane, attempt, timeout and occupancy registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         carril        <= 1'b0;
         ultimo_carril <= 1'b1;
         intentos      <= '0;
         timer         <= '0;
         ocupacion     <= '0;
      end else begin
         carril        <= carril_sig;
         ultimo_carril <= ultimo_sig;
         intentos      <= intentos_sig;
         timer         <= timer_sig;
         ocupacion     <= ocup_sig;
      end
   end

   // Registered Moore outputs, decoded from the state being entered.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         habilitar_pin        <= 1'b0;
         senal_compuerta      <= 1'b0;
         senal_alarma_pin     <= 1'b0;
         senal_alarma_bloqueo <= 1'b0;
      end else begin
         habilitar_pin        <= (estado_sig == VERIFICANDO);
         senal_compuerta      <= (estado_sig == ABIERTA);
         senal_alarma_pin     <= alarma_pin_sig;
         senal_alarma_bloqueo <= (estado_sig == BLOQUEO);
      end
   end

endmodule

// File: tb/tb_arbitro_compuerta.sv
// tb_arbitro_compuerta: directed bench for the parking gate arbiter.
module tb_arbitro_compuerta;

   logic       clock;
   logic       reset;
   logic       llegada_entrada;
   logic       llegada_salida;
   logic       pin_valido;
   logic       pin_invalido;
   logic       sensor_paso;
   logic       desbloqueo;
   logic       habilitar_pin;
   logic       carril;
   logic       senal_compuerta;
   logic       senal_alarma_pin;
   logic       senal_alarma_bloqueo;
   logic       senal_lleno;
   logic [3:0] ocupacion;

   int n_checks = 0;
   int n_fail   = 0;

   arbitro_compuerta #(
      .CAPACIDAD(8), .ANCHO_OCUP(4), .MAX_INTENTOS(3), .TIMEOUT(1000), .ANCHO_TMR(10)
   ) dut (
      .clock(clock), .reset(reset),
      .llegada_entrada(llegada_entrada), .llegada_salida(llegada_salida),
      .pin_valido(pin_valido), .pin_invalido(pin_invalido),
      .sensor_paso(sensor_paso), .desbloqueo(desbloqueo),
      .habilitar_pin(habilitar_pin), .carril(carril),
      .senal_compuerta(senal_compuerta), .senal_alarma_pin(senal_alarma_pin),
      .senal_alarma_bloqueo(senal_alarma_bloqueo), .senal_lleno(senal_lleno),
      .ocupacion(ocupacion)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // From VERIFICANDO: valid PIN, then the vehicle crosses.
   task automatic pasar();
      pin_valido = 1'b1; tick(); pin_valido = 1'b0;
      sensor_paso = 1'b1; tick(); sensor_paso = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      llegada_entrada = 0; llegada_salida = 0; pin_valido = 0; pin_invalido = 0;
      sensor_paso = 0; desbloqueo = 0;
      tick(); tick();
      n_checks++;
      if ({habilitar_pin, carril, senal_compuerta, senal_alarma_pin, senal_alarma_bloqueo, senal_lleno} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b required 000000",
                  {habilitar_pin, carril, senal_compuerta, senal_alarma_pin, senal_alarma_bloqueo, senal_lleno});
      end
      n_checks++;
      if (ocupacion !== 4'd0) begin n_fail++; $display("FAIL reset_ocupacion: got %0d required 0", ocupacion); end
      @(negedge clock); reset = 1'b1;
   endtask

   task automatic test_entrada_simple();
      tick();
      llegada_entrada = 1'b1;
      n_checks++;
      if (habilitar_pin !== 1'b0) begin n_fail++; $display("FAIL t1_pre_grant: habilitar_pin=%b required 0", habilitar_pin); end
      tick();
      n_checks++;
      if (habilitar_pin !== 1'b1 || carril !== 1'b0) begin
         n_fail++; $display("FAIL t1_grant: habilitar_pin=%b carril=%b required 1 0", habilitar_pin, carril);
      end
      pin_valido = 1'b1; tick(); pin_valido = 1'b0;
      n_checks++;
      if (senal_compuerta !== 1'b1 || habilitar_pin !== 1'b0) begin
         n_fail++; $display("FAIL t1_gate_open: compuerta=%b habilitar=%b required 1 0", senal_compuerta, habilitar_pin);
      end
      llegada_entrada = 1'b0;
      sensor_paso = 1'b1; tick(); sensor_paso = 1'b0;
      n_checks++;
      if (senal_compuerta !== 1'b0 || ocupacion !== 4'd1) begin
         n_fail++; $display("FAIL t1_passage: compuerta=%b ocupacion=%0d required 0 1", senal_compuerta, ocupacion);
      end
      tick();
      n_checks++;
      if (habilitar_pin !== 1'b0) begin n_fail++; $display("FAIL t1_idle: habilitar_pin=%b required 0", habilitar_pin); end
   endtask

   task automatic test_alternancia();
      // Bring occupancy to 2 with the exit lane served last.
      llegada_entrada = 1'b1;
      tick(); pasar();
      tick(); pasar();
      llegada_entrada = 1'b0; llegada_salida = 1'b1;
      tick(); pasar();
      n_checks++;
      if (ocupacion !== 4'd2) begin n_fail++; $display("FAIL t2_setup: ocupacion=%0d required 2", ocupacion); end
      llegada_entrada = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (habilitar_pin !== 1'b1 || carril !== i[0]) begin
            n_fail++; $display("FAIL t2_grant%0d: habilitar=%b carril=%b required 1 %b", i, habilitar_pin, carril, i[0]);
         end
         pasar();
         n_checks++;
         if (ocupacion !== (i[0] ? 4'd2 : 4'd3)) begin
            n_fail++; $display("FAIL t2_ocup%0d: ocupacion=%0d required %0d", i, ocupacion, i[0] ? 2 : 3);
         end
      end
      llegada_salida = 1'b0;
   endtask

   task automatic test_bloqueo();
      // Entry still requested; next edge grants entry.
      tick();
      n_checks++;
      if (habilitar_pin !== 1'b1 || carril !== 1'b0) begin
         n_fail++; $display("FAIL t3_grant: habilitar=%b carril=%b required 1 0", habilitar_pin, carril);
      end
      for (int r = 0; r < 2; r++) begin
         for (int k = 1; k <= 3; k++) begin
            pin_invalido = 1'b1; tick(); pin_invalido = 1'b0;
            n_checks++;
            if (senal_alarma_pin !== 1'b1 || senal_alarma_bloqueo !== (k == 3)) begin
               n_fail++; $display("FAIL t3_bad%0d_%0d: alarma_pin=%b bloqueo=%b required 1 %b",
                                  r, k, senal_alarma_pin, senal_alarma_bloqueo, (k == 3));
            end
         end
         pin_valido = 1'b1; llegada_salida = 1'b1;
         tick(); tick();
         pin_valido = 1'b0;
         n_checks++;
         if (senal_alarma_bloqueo !== 1'b1 || habilitar_pin !== 1'b0 || senal_alarma_pin !== 1'b0 || senal_compuerta !== 1'b0) begin
            n_fail++; $display("FAIL t3_locked%0d: bloqueo=%b habilitar=%b alarma_pin=%b compuerta=%b required 1 0 0 0",
                               r, senal_alarma_bloqueo, habilitar_pin, senal_alarma_pin, senal_compuerta);
         end
         llegada_salida = 1'b0;
         desbloqueo = 1'b1; tick(); desbloqueo = 1'b0;
         n_checks++;
         if (senal_alarma_bloqueo !== 1'b0 || habilitar_pin !== 1'b0) begin
            n_fail++; $display("FAIL t3_unlock%0d: bloqueo=%b habilitar=%b required 0 0", r, senal_alarma_bloqueo, habilitar_pin);
         end
         tick();
      end
      pasar();
      n_checks++;
      if (ocupacion !== 4'd4) begin n_fail++; $display("FAIL t3_after: ocupacion=%0d required 4", ocupacion); end
   endtask

   task automatic test_lleno();
      for (int i = 0; i < 4; i++) begin
         tick(); pasar();
      end
      n_checks++;
      if (ocupacion !== 4'd8 || senal_lleno !== 1'b1) begin
         n_fail++; $display("FAIL t4_full: ocupacion=%0d lleno=%b required 8 1", ocupacion, senal_lleno);
      end
      tick(); tick();
      n_checks++;
      if (habilitar_pin !== 1'b0) begin n_fail++; $display("FAIL t4_entry_refused: habilitar=%b required 0", habilitar_pin); end
      llegada_salida = 1'b1;
      tick();
      n_checks++;
      if (habilitar_pin !== 1'b1 || carril !== 1'b1) begin
         n_fail++; $display("FAIL t4_exit_grant: habilitar=%b carril=%b required 1 1", habilitar_pin, carril);
      end
      pasar();
      llegada_salida = 1'b0; llegada_entrada = 1'b0;
      n_checks++;
      if (ocupacion !== 4'd7 || senal_lleno !== 1'b0) begin
         n_fail++; $display("FAIL t4_not_full: ocupacion=%0d lleno=%b required 7 0", ocupacion, senal_lleno);
      end
   endtask

   task automatic test_timeout();
      int abierta = 0;
      llegada_entrada = 1'b1;
      tick();
      for (int i = 0; i < 999; i++) begin
         tick();
         if (senal_compuerta !== 1'b0) abierta++;
      end
      n_checks++;
      if (habilitar_pin !== 1'b1) begin n_fail++; $display("FAIL t5_before_timeout: habilitar=%b required 1", habilitar_pin); end
      tick();
      n_checks++;
      if (habilitar_pin !== 1'b0 || senal_compuerta !== 1'b0) begin
         n_fail++; $display("FAIL t5_timeout: habilitar=%b compuerta=%b required 0 0", habilitar_pin, senal_compuerta);
      end
      n_checks++;
      if (abierta !== 0) begin n_fail++; $display("FAIL t5_gate_closed: open cycles=%0d required 0", abierta); end
      llegada_entrada = 1'b0; tick();
      llegada_entrada = 1'b1; tick(); tick(); tick();
      llegada_entrada = 1'b0; tick();
      n_checks++;
      if (habilitar_pin !== 1'b0 || ocupacion !== 4'd7) begin
         n_fail++; $display("FAIL t5_abandon: habilitar=%b ocupacion=%0d required 0 7", habilitar_pin, ocupacion);
      end
   endtask

   task automatic test_reset_abierta();
      llegada_entrada = 1'b1; tick();
      pin_valido = 1'b1; tick(); pin_valido = 1'b0;
      n_checks++;
      if (senal_compuerta !== 1'b1) begin n_fail++; $display("FAIL t6_open: compuerta=%b required 1", senal_compuerta); end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (senal_compuerta !== 1'b0 || ocupacion !== 4'd0 || habilitar_pin !== 1'b0) begin
         n_fail++; $display("FAIL t6_async_reset: compuerta=%b ocupacion=%0d habilitar=%b required 0 0 0",
                            senal_compuerta, ocupacion, habilitar_pin);
      end
      llegada_entrada = 1'b0;
      @(negedge clock); reset = 1'b1;
      pin_valido = 1'b1; tick(); pin_valido = 1'b0;
      n_checks++;
      if (senal_compuerta !== 1'b0 || habilitar_pin !== 1'b0) begin
         n_fail++; $display("FAIL t6_pin_idle: compuerta=%b habilitar=%b required 0 0", senal_compuerta, habilitar_pin);
      end
      llegada_entrada = 1'b1; tick();
      pin_valido = 1'b1; pin_invalido = 1'b1; tick();
      pin_valido = 1'b0; pin_invalido = 1'b0;
      n_checks++;
      if (senal_alarma_pin !== 1'b1 || senal_compuerta !== 1'b0 || habilitar_pin !== 1'b1) begin
         n_fail++; $display("FAIL t6_both_pins: alarma_pin=%b compuerta=%b habilitar=%b required 1 0 1",
                            senal_alarma_pin, senal_compuerta, habilitar_pin);
      end
      llegada_entrada = 1'b0; tick();
   endtask

   initial begin
      test_reset();
      test_entrada_simple();
      test_alternancia();
      test_bloqueo();
      test_lleno();
      test_timeout();
      test_reset_abierta();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d required completion", n_checks);
      $fatal(1);
   end

endmodule
